// File: rtl/seg_pkg.sv
// Shared definitions for the multiplexed seven-segment display controller:
// register map, CTRL field positions, reset constants and the hex decode table.
package seg_pkg;

  localparam logic [1:0] ADDR_VALUE = 2'd0;
  localparam logic [1:0] ADDR_DP    = 2'd1;
  localparam logic [1:0] ADDR_BLANK = 2'd2;
  localparam logic [1:0] ADDR_CTRL  = 2'd3;

  localparam int CTRL_EN_BIT  = 0;
  localparam int CTRL_BRI_LSB = 4;
  localparam int CTRL_BRI_MSB = 7;

  localparam logic [31:0] CTRL_RST  = 32'h0000_00F0;
  localparam int          PWM_STEPS = 16;

  // Active-high gfedcba pattern for one hex nibble.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg_display_mux_if.sv
// Register-bus connection between a bus master and the display controller.
interface seg_display_mux_if;

    logic [1:0]  address;
    logic        write;
    logic [31:0] writedata;
    logic        read;
    logic [31:0] readdata;

    modport master (output address, output write, output writedata, output read,
                    input readdata);
    modport slave  (input address, input write, input writedata, input read,
                    output readdata);

endinterface

// File: rtl/hex7seg.sv
// Combinational hex nibble to active-high seven-segment decoder.
module hex7seg
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] segments
);

    assign segments = hex_to_seg(nibble);

endmodule

// File: rtl/seg_display_mux.sv
// Multiplexed DIGITS-digit seven-segment controller with PWM brightness,
// per-digit dp/blank and frame-synchronous double-buffered digit values.
module seg_display_mux
    import seg_pkg::*;
#(
    parameter int DIGITS         = 4,
    parameter int PRESCALE       = 3125,
    parameter bit SEL_ACTIVE_LOW = 1'b1,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    seg_display_mux_if.slave  bus,
    output logic [DIGITS-1:0] display_select,
    output logic [7:0]        display_segment
);

    localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int VAL_W = 4 * DIGITS;

    function automatic logic [DIGITS-1:0] sel_pol(input logic [DIGITS-1:0] s);
        return SEL_ACTIVE_LOW ? ~s : s;
    endfunction

    function automatic logic [7:0] seg_pol(input logic [7:0] s);
        return SEG_ACTIVE_LOW ? ~s : s;
    endfunction

    logic [PRE_W-1:0]  pre_cnt;
    logic [3:0]        phase;
    logic [IDX_W-1:0]  idx;
    logic              tick, phase_wrap, frame_wrap;

    logic [VAL_W-1:0]  shadow_val, active_val;
    logic [DIGITS-1:0] dp, blank;
    logic              en;
    logic [3:0]        bri;
    logic [31:0]       rd_mux;
    logic              unused_wdata;

    logic [3:0]        nib_p0;
    logic [6:0]        hex_p0;
    logic              lit_p0;
    logic [DIGITS-1:0] onehot_p0;

    assign unused_wdata = ^bus.writedata;

    assign tick       = (pre_cnt == PRE_W'(PRESCALE - 1));
    assign phase_wrap = tick && (phase == 4'(PWM_STEPS - 1));
    assign frame_wrap = phase_wrap && (idx == IDX_W'(DIGITS - 1));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pre_cnt <= '0;
            phase   <= '0;
            idx     <= '0;
        end else begin
            pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
            if (tick)
                phase <= phase + 1'b1;
            if (phase_wrap)
                idx <= frame_wrap ? '0 : idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            shadow_val <= '0;
            dp         <= '0;
            blank      <= '0;
            en         <= CTRL_RST[CTRL_EN_BIT];
            bri        <= CTRL_RST[CTRL_BRI_MSB:CTRL_BRI_LSB];
        end else if (bus.write) begin
            case (bus.address)
                ADDR_VALUE: shadow_val <= bus.writedata[VAL_W-1:0];
                ADDR_DP:    dp         <= bus.writedata[DIGITS-1:0];
                ADDR_BLANK: blank      <= bus.writedata[DIGITS-1:0];
                default: begin
                    en  <= bus.writedata[CTRL_EN_BIT];
                    bri <= bus.writedata[CTRL_BRI_MSB:CTRL_BRI_LSB];
                end
            endcase
        end
    end

    // A VALUE write on the wrap edge only reaches shadow; active takes the old shadow.
    always_ff @(posedge clk) begin
        if (!reset_n)
            active_val <= '0;
        else if (frame_wrap)
            active_val <= shadow_val;
    end

    always_comb begin
        rd_mux = '0;
        case (bus.address)
            ADDR_VALUE: rd_mux[VAL_W-1:0]  = shadow_val;
            ADDR_DP:    rd_mux[DIGITS-1:0] = dp;
            ADDR_BLANK: rd_mux[DIGITS-1:0] = blank;
            default: begin
                rd_mux[CTRL_EN_BIT]               = en;
                rd_mux[CTRL_BRI_MSB:CTRL_BRI_LSB] = bri;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n)
            bus.readdata <= '0;
        else if (bus.read)
            bus.readdata <= rd_mux;
    end

    // Stage p0: decode the current digit slot from the timing chain state.
    assign nib_p0    = active_val[idx*4 +: 4];
    assign lit_p0    = en && !blank[idx] && (phase <= bri);
    assign onehot_p0 = DIGITS'(1) << idx;

    hex7seg u_hex7seg (
        .nibble   (nib_p0),
        .segments (hex_p0)
    );

    // Stage p1: registered pins, polarity applied last.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            display_select  <= sel_pol('0);
            display_segment <= seg_pol('0);
        end else if (lit_p0) begin
            display_select  <= sel_pol(onehot_p0);
            display_segment <= seg_pol({dp[idx], hex_p0});
        end else begin
            display_select  <= sel_pol('0);
            display_segment <= seg_pol('0);
        end
    end

endmodule

// File: tb/tb_seg_display_mux.sv
// Bench for seg_display_mux: time-indexed reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_seg_display_mux;

    localparam int P = 2;
    localparam int D = 4;
    localparam int SLOT = 16 * P;
    localparam int FRAME = SLOT * D;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] display_select;
    logic [7:0] display_segment;

    seg_display_mux_if bus ();

    seg_display_mux #(
        .DIGITS         (D),
        .PRESCALE       (P),
        .SEL_ACTIVE_LOW (1'b1),
        .SEG_ACTIVE_LOW (1'b1)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .bus             (bus),
        .display_select  (display_select),
        .display_segment (display_segment)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] seg_of(input logic [3:0] n);
        logic [6:0] t [16];
        t = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        return t[n];
    endfunction

    // Reference model: display position derived from cycles since reset.
    logic [15:0] m_shadow, m_active;
    logic [3:0]  m_dp, m_blank, m_bri;
    logic        m_en;
    int          m_t;
    logic [3:0]  exp_sel;
    logic [7:0]  exp_seg;
    logic [31:0] exp_rd;
    bit          model_ok = 1'b0;

    always @(posedge clk) begin
        int         ph, ix;
        bit         lit;
        logic [3:0] nib;
        if (!reset_n) begin
            m_shadow <= '0; m_active <= '0; m_dp <= '0; m_blank <= '0;
            m_en <= 1'b0; m_bri <= 4'hF; m_t <= 0;
            exp_sel <= 4'hF; exp_seg <= 8'hFF; exp_rd <= '0;
            model_ok <= 1'b1;
        end else begin
            ph  = (m_t / P) % 16;
            ix  = (m_t / SLOT) % D;
            lit = m_en && !m_blank[ix] && (ph <= int'(m_bri));
            nib = m_active[ix*4 +: 4];
            exp_sel <= lit ? ~(4'b0001 << ix) : 4'hF;
            exp_seg <= lit ? ~{m_dp[ix], seg_of(nib)} : 8'hFF;
            if (bus.read) begin
                case (bus.address)
                    2'd0: exp_rd <= {16'h0, m_shadow};
                    2'd1: exp_rd <= {28'h0, m_dp};
                    2'd2: exp_rd <= {28'h0, m_blank};
                    default: exp_rd <= {24'h0, m_bri, 3'b000, m_en};
                endcase
            end
            if (bus.write) begin
                case (bus.address)
                    2'd0: m_shadow <= bus.writedata[15:0];
                    2'd1: m_dp <= bus.writedata[3:0];
                    2'd2: m_blank <= bus.writedata[3:0];
                    default: begin
                        m_en  <= bus.writedata[0];
                        m_bri <= bus.writedata[7:4];
                    end
                endcase
            end
            m_t <= m_t + 1;
            if ((m_t + 1) % FRAME == 0)
                m_active <= m_shadow;
        end
    end

    always @(negedge clk) begin
        if (model_ok) begin
            check("model_select", {28'h0, display_select}, {28'h0, exp_sel});
            check("model_segment", {24'h0, display_segment}, {24'h0, exp_seg});
            check("model_readdata", bus.readdata, exp_rd);
        end
    end

    task automatic write_reg(input logic [1:0] a, input logic [31:0] d);
        bus.address = a; bus.writedata = d; bus.write = 1'b1;
        @(negedge clk);
        bus.write = 1'b0;
    endtask

    task automatic read_reg(input logic [1:0] a, output logic [31:0] d);
        bus.address = a; bus.read = 1'b1;
        @(negedge clk);
        bus.read = 1'b0;
        d = bus.readdata;
    endtask

    task automatic wait_sel(input logic [3:0] s, input int budget);
        int n = 0;
        while (display_select !== s && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (display_select !== s) begin
            total++;
            bad++;
            $display("FAIL wait_select actual=%h required=%h after %0d cycles", display_select, s, budget);
        end
    endtask

    initial begin
        logic [31:0] rd;
        logic [3:0]  sel_tab [4];
        logic [7:0]  seg_tab [4];
        logic [7:0]  seg_seen;
        int          cnt, d1_cnt;

        bus.address = '0; bus.write = 1'b0; bus.writedata = '0; bus.read = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_select", {28'h0, display_select}, 32'h0000000F);
        check("reset_segment", {24'h0, display_segment}, 32'h000000FF);
        check("reset_readdata", bus.readdata, 32'h0);
        reset_n = 1'b1;
        read_reg(2'd3, rd);
        check("reset_ctrl_read", rd, 32'h000000F0);
        read_reg(2'd0, rd);
        check("reset_value_read", rd, 32'h0);

        // Basic scan of all four digits at full brightness.
        write_reg(2'd0, 32'h0000A1C3);
        write_reg(2'd3, 32'h000000F1);
        sel_tab = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        seg_tab = '{8'hB0, 8'hC6, 8'hF9, 8'h88};
        wait_sel(4'b0111, 2 * FRAME);
        wait_sel(4'b1110, SLOT + 4);
        for (int d = 0; d < 4; d++) begin
            check("scan_select", {28'h0, display_select}, {28'h0, sel_tab[d]});
            check("scan_segment", {24'h0, display_segment}, {24'h0, seg_tab[d]});
            cnt = 0;
            while (display_select === sel_tab[d] && cnt < 2 * SLOT) begin
                @(negedge clk);
                cnt++;
            end
            check("scan_hold_cycles", cnt, SLOT);
        end

        // Mid-frame VALUE write: shadow reads back at once, display waits for the wrap.
        write_reg(2'd0, 32'h00008888);
        read_reg(2'd0, rd);
        check("dbuf_shadow_read", rd, 32'h00008888);
        wait_sel(4'b1011, FRAME);
        check("dbuf_old_digit2", {24'h0, display_segment}, 32'h000000F9);
        wait_sel(4'b1110, FRAME);
        check("dbuf_new_digit0", {24'h0, display_segment}, 32'h00000080);

        // Brightness 3: four PWM phases lit out of sixteen.
        write_reg(2'd3, 32'h00000031);
        wait_sel(4'b0111, 2 * FRAME);
        wait_sel(4'b1110, SLOT + 4);
        cnt = 0;
        while (display_select === 4'b1110 && cnt < 2 * SLOT) begin
            @(negedge clk);
            cnt++;
        end
        check("bright_lit_cycles", cnt, 8);
        cnt = 0;
        while (display_select === 4'b1111 && cnt < 2 * SLOT) begin
            @(negedge clk);
            cnt++;
        end
        check("bright_dark_cycles", cnt, 24);
        check("bright_next_digit", {28'h0, display_select}, 32'h0000000D);

        // Decimal points on digits 0 and 2, digit 1 blanked.
        write_reg(2'd1, 32'h5);
        write_reg(2'd2, 32'h2);
        write_reg(2'd3, 32'hF1);
        wait_sel(4'b0111, 2 * FRAME);
        check("dp_digit3_off", {24'h0, display_segment}, 32'h00000080);
        wait_sel(4'b1110, SLOT + 4);
        check("dp_digit0_on", {24'h0, display_segment}, 32'h00000000);
        d1_cnt = 0;
        seg_seen = 8'hFF;
        for (int i = 0; i < FRAME; i++) begin
            if (display_select === 4'b1101) d1_cnt++;
            if (display_select === 4'b1011) seg_seen = display_segment;
            @(negedge clk);
        end
        check("blank_digit1_cycles", d1_cnt, 0);
        check("dp_digit2_on", {24'h0, seg_seen}, 32'h00000000);

        // Random register traffic, checked by the model every cycle.
        for (int i = 0; i < 2000; i++) begin
            logic [31:0] r;
            r = $urandom;
            bus.address   = r[5:4];
            bus.write     = (r[2:0] == 3'd0);
            bus.read      = r[3];
            bus.writedata = $urandom;
            if (r[5:4] == 2'd3 && r[7:6] != 2'd0) bus.writedata[0] = 1'b1;
            @(negedge clk);
        end
        bus.write = 1'b0;
        bus.read  = 1'b0;

        // Reset in the middle of digit 2.
        write_reg(2'd2, 32'h0);
        write_reg(2'd3, 32'hF1);
        wait_sel(4'b1011, 2 * FRAME);
        reset_n = 1'b0;
        @(negedge clk);
        check("midreset_select", {28'h0, display_select}, 32'h0000000F);
        check("midreset_segment", {24'h0, display_segment}, 32'h000000FF);
        reset_n = 1'b1;
        read_reg(2'd0, rd);
        check("midreset_value", rd, 32'h0);
        read_reg(2'd3, rd);
        check("midreset_ctrl", rd, 32'h000000F0);
        read_reg(2'd1, rd);
        check("midreset_dp", rd, 32'h0);
        repeat (SLOT) @(negedge clk);
        check("midreset_disabled", {28'h0, display_select}, 32'h0000000F);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seg_display_mux.md
Name: seg_display_mux

Overview:
Parametrised multiplexed seven-segment display controller. Successor to the fixed 4-digit segment display block in the system top.
Generalised to DIGITS digits, with:
- per-digit decimal points and blanking
- 16-level PWM brightness
- selectable output polarity
- frame-synchronous double-buffered digit values (no tearing)
Sits on the system bus as a small register-mapped slave and drives display select/segment pins directly.

Parameters:
DIGITS, 4, number of multiplexed digits; legal 1..8
PRESCALE, 3125, clk cycles per PWM tick; 16 ticks per digit slot (50 MHz -> 1 ms/digit); legal >= 1
SEL_ACTIVE_LOW, 1, 1 = display_select asserted low
SEG_ACTIVE_LOW, 1, 1 = display_segment lit low

Ports:
clk  input  1  system clock
reset_n  input  1  synchronous, active-low reset
address  input  2  register index
write  input  1  write strobe, single cycle
writedata  input  32  write data
read  input  1  read strobe
readdata  output  32  read data, valid 1 cycle after read
display_select  output  DIGITS  one-hot digit enable (polarity per SEL_ACTIVE_LOW)
display_segment  output  8  bit7 = dp, bits6:0 = g..a (polarity per SEG_ACTIVE_LOW)

Behaviour:
- Interface: one clock (clk); reset_n is synchronous and active-low, sampled on the rising edge of clk only.
- Register map (writes take effect at the next edge unless noted):
  - 0 VALUE: 4-bit hex nibble per digit; digit i = bits[4i+3:4i]; bits >= 4*DIGITS ignored on write, read 0. Writes go to the shadow copy.
  - 1 DP: bits[DIGITS-1:0] per-digit decimal point.
  - 2 BLANK: bits[DIGITS-1:0]; 1 = digit dark regardless of value/dp.
  - 3 CTRL: bit0 enable; bits[7:4] brightness B (0..15); other bits read 0.
- Reset values: shadow and active VALUE = 0, DP = 0, BLANK = 0, CTRL = 0x000000F0 (disabled, full brightness), readdata = 0, all counters 0.
  - Outputs at reset: all select lines inactive, all segments unlit.
- Read: readdata registered, 1-cycle latency. VALUE reads return shadow. readdata holds its value when read = 0.
- Simultaneous read and write to the same address returns the old value.
- Timing chain:
  - Prescale counter 0..PRESCALE-1; wrap produces a tick.
  - PWM phase 0..15 advances on tick.
  - Phase wrap 15->0 advances digit index 0..DIGITS-1, wrapping to 0.
- Frame boundary: the cycle the digit index wraps DIGITS-1 -> 0 (for DIGITS = 1, every phase wrap).
  - On that edge, shadow VALUE is copied into active VALUE.
  - A write to VALUE on that same edge lands in shadow only and is copied at the next frame.
  - DP, BLANK and CTRL are not buffered; they apply immediately.
- Lit condition: enable = 1 AND BLANK[idx] = 0 AND phase <= B.
  - B = 15 gives 100% duty; B = 0 gives 1/16.
- Outputs are registered, updated together each cycle.
  - When lit: select = one-hot idx; segment[6:0] = hex7seg(active nibble), segment[7] = DP[idx].
  - When not lit: select all inactive, segments all unlit.
  - Polarity inversion is applied last.
- Decode table (gfedcba, active-high):
  - 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07
  - 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71
- enable 1->0 blanks outputs on the next edge; counters keep running.
- Reset mid-frame: everything returns to reset values on that edge; no partial output.

Decomposition:
- Shared package seg_pkg: register address constants (ADDR_VALUE, ADDR_DP, ADDR_BLANK, ADDR_CTRL), CTRL bit positions, reset constant CTRL_RST = 0xF0, PWM_STEPS = 16, hex-to-segment lookup function.
- One sub-module hex7seg: 4-bit nibble in, 7-bit active-high segments out, combinational.
- Timing chain, registers, double buffer and output stage stay in the top.

Test Plan:
- Reset: reset_n low for 2 cycles with default params -> select = 4'b1111, segment = 8'hFF, readdata = 0 after read of address 3 returns 0x000000F0.
- Basic scan (PRESCALE = 2): write VALUE = 0x0000A1C3, CTRL = 0xF1 -> digits 0..3 show segments (inverted) 0xB0, 0xC6, 0xF9, 0x88; select 1110, 1101, 1011, 0111; each digit held 32 cycles.
- Double buffer: mid-frame write VALUE = 0x8888 -> active digits unchanged until the frame wrap edge; read VALUE returns 0x8888 immediately.
- Brightness (PRESCALE = 2): CTRL = 0x31 -> per digit slot, lit for phases 0..3 (8 cycles), dark for 24 cycles.
- DP/BLANK: DP = 0x5, BLANK = 0x2 -> digits 0 and 2 show segment bit7 = 0 (lit); digit 1 select never asserted.
- Reset mid-operation: assert reset_n low during digit 2 -> next edge outputs inactive; after release, VALUE reads 0 and CTRL reads 0xF0.
